// File: rtl/var_mac_if.sv
// Stream and result handshake bundle for the var_mac dot-product stage.
// The producer/consumer side takes master, the MAC takes slave.
interface var_mac_if;
    logic               start;
    logic signed [19:0] bias;
    logic signed [19:0] x_in;
    logic signed [19:0] w_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] V_out;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output start, bias, x_in, w_in, in_valid, out_ready,
        input  in_ready, V_out, out_valid
    );

    modport slave (
        input  start, bias, x_in, w_in, in_valid, out_ready,
        output in_ready, V_out, out_valid
    );
endinterface

// File: rtl/var_mac.sv
// Pipelined Q5.15 multiply-accumulate: V_out = bias + sum(x*w), saturated.
// One registered product in flight, accumulated in Q10.30 one edge later.
module var_mac #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst,
    var_mac_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    localparam logic [8:0] LAST = 9'(N - 1);

    state_t             state;
    state_t             state_nx;
    logic [8:0]         cnt;
    logic signed [47:0] acc;
    logic signed [39:0] prod_q;
    logic               prod_v;
    logic signed [19:0] v_q;

    logic               hs;
    logic signed [39:0] prod_d;
    logic signed [47:0] sum;
    logic signed [47:0] shf;
    logic signed [19:0] sat;

    assign hs     = bus.in_valid && (state == ACC);
    assign prod_d = 40'(bus.x_in) * 40'(bus.w_in);
    assign sum    = acc + (prod_v ? 48'(prod_q) : 48'sd0);
    assign shf    = sum >>> 15;

    always_comb begin
        sat = shf[19:0];
        if (shf > 48'sd524287)
            sat = 20'sh7FFFF;
        else if (shf < -48'sd524288)
            sat = 20'sh80000;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start) state_nx = ACC;
            ACC:   if (hs && cnt == LAST) state_nx = DRAIN;
            DRAIN: state_nx = DONE;
            DONE:  if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == DONE);
    end

    assign bus.V_out = v_q;

    // acc always absorbs the product in flight, so sum is the next acc
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
            prod_v <= 1'b0;
            v_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= {{13{bus.bias[19]}}, bus.bias, 15'b0};
                        cnt    <= '0;
                        prod_v <= 1'b0;
                    end
                end
                ACC: begin
                    acc    <= sum;
                    prod_v <= hs;
                    if (hs) begin
                        prod_q <= prod_d;
                        cnt    <= cnt + 9'd1;
                    end
                end
                DRAIN: begin
                    acc    <= sum;
                    prod_v <= 1'b0;
                    v_q    <= sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_var_mac.sv
// Bench for var_mac: four instances (N = 1, 2, 4, 16) driven by directed
// steps with random data, checked against an integer dot-product model.
module tb_var_mac;

    logic clk;
    logic rst;

    logic               start_s [4];
    logic signed [19:0] bias_s  [4];
    logic signed [19:0] x_s     [4];
    logic signed [19:0] w_s     [4];
    logic               iv_s    [4];
    logic               ordy_s  [4];
    logic [3:0]         irdy_s;
    logic [3:0]         ov_s;
    logic [3:0][19:0]   v_s;

    logic signed [19:0] xs [256];
    logic signed [19:0] ws [256];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        var_mac_if u_if ();
        assign u_if.start     = start_s[g];
        assign u_if.bias      = bias_s[g];
        assign u_if.x_in      = x_s[g];
        assign u_if.w_in      = w_s[g];
        assign u_if.in_valid  = iv_s[g];
        assign u_if.out_ready = ordy_s[g];
        assign irdy_s[g]      = u_if.in_ready;
        assign ov_s[g]        = u_if.out_valid;
        assign v_s[g]         = u_if.V_out;
        var_mac #(.N(NV)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bias + sum(x*w) in exact integers, floored back to Q5.15 and clamped
    function automatic logic [19:0] model(input int n, input logic signed [19:0] b);
        longint s;
        s = longint'(b) * 32768;
        for (int k = 0; k < n; k++)
            s += longint'(xs[k]) * longint'(ws[k]);
        s = s >>> 15;
        if (s > 524287)
            s = 524287;
        else if (s < -524288)
            s = -524288;
        return 20'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int d, input int n, input logic signed [19:0] b,
                          input bit bub, input string tag, output int edges);
        int k;
        bit hs;
        start_s[d] = 1'b1;
        bias_s[d]  = b;
        tick();
        start_s[d] = 1'b0;
        bias_s[d]  = 20'($urandom);
        edges = 0;
        k = 0;
        while (!ov_s[d] && edges < 500) begin
            iv_s[d] = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (k >= n && irdy_s[d])
                iv_s[d] = 1'b0;
            x_s[d]    = (k < n) ? xs[k] : 20'($urandom);
            w_s[d]    = (k < n) ? ws[k] : 20'($urandom);
            ordy_s[d] = bub ? 1'($urandom_range(0, 1)) : 1'b0;
            hs = iv_s[d] && irdy_s[d];
            tick();
            edges++;
            if (hs)
                k++;
        end
        iv_s[d]   = 1'b0;
        ordy_s[d] = 1'b0;
        chk({tag, "_valid"}, 32'(ov_s[d]), 32'd1);
        chk({tag, "_count"}, 32'(k), 32'(n));
        chk({tag, "_v"}, 32'(v_s[d]), 32'(model(n, b)));
    endtask

    task automatic accept(input int d, input int hold, input bit poke,
                          input string tag);
        logic [19:0] v0;
        v0 = v_s[d];
        for (int i = 0; i < hold; i++) begin
            start_s[d] = poke;
            iv_s[d]    = poke;
            tick();
            chk({tag, "_hold_v"}, 32'(v_s[d]), 32'(v0));
            chk({tag, "_hold_ov"}, 32'(ov_s[d]), 32'd1);
            chk({tag, "_hold_ir"}, 32'(irdy_s[d]), 32'd0);
        end
        start_s[d] = 1'b0;
        iv_s[d]    = 1'b0;
        ordy_s[d]  = 1'b1;
        tick();
        ordy_s[d] = 1'b0;
        chk({tag, "_acc_ov"}, 32'(ov_s[d]), 32'd0);
        chk({tag, "_acc_v"}, 32'(v_s[d]), 32'(v0));
        tick();
        chk({tag, "_idle_ov"}, 32'(ov_s[d]), 32'd0);
        chk({tag, "_idle_ir"}, 32'(irdy_s[d]), 32'd0);
    endtask

    initial begin
        int e;
        logic signed [19:0] b;
        n_cmp = 0;
        n_bad = 0;
        for (int d = 0; d < 4; d++) begin
            start_s[d] = 1'b0;
            bias_s[d]  = '0;
            x_s[d]     = '0;
            w_s[d]     = '0;
            iv_s[d]    = 1'b0;
            ordy_s[d]  = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_v%0d", d), 32'(v_s[d]), 32'd0);
            chk($sformatf("rst_ov%0d", d), 32'(ov_s[d]), 32'd0);
            chk($sformatf("rst_ir%0d", d), 32'(irdy_s[d]), 32'd0);
        end

        // basic dot product, N=2
        xs[0] = 20'sh08000; ws[0] = 20'sh04000;
        xs[1] = 20'sh10000; ws[1] = 20'shFC000;
        run_op(1, 2, 20'sh00000, 1'b0, "basic", e);
        chk("basic_const", 32'(v_s[1]), 32'(20'hFC000));
        chk("basic_lat", 32'(e), 32'd3);
        accept(1, 0, 1'b0, "basic");

        // bias only, N=4
        for (int k = 0; k < 4; k++) begin
            xs[k] = '0;
            ws[k] = 20'($urandom);
        end
        run_op(2, 4, 20'sh18000, 1'b0, "bias", e);
        chk("bias_const", 32'(v_s[2]), 32'(20'h18000));
        chk("bias_lat", 32'(e), 32'd5);
        accept(2, 1, 1'b0, "bias");

        // saturation, N=1
        xs[0] = 20'sh7FFFF; ws[0] = 20'sh7FFFF;
        run_op(0, 1, 20'sh00000, 1'b0, "sat_hi", e);
        chk("sat_hi_const", 32'(v_s[0]), 32'(20'h7FFFF));
        accept(0, 0, 1'b0, "sat_hi");
        xs[0] = 20'sh80000; ws[0] = 20'sh7FFFF;
        run_op(0, 1, 20'sh00000, 1'b0, "sat_lo", e);
        chk("sat_lo_const", 32'(v_s[0]), 32'(20'h80000));
        accept(0, 0, 1'b0, "sat_lo");

        // floor rounding
        xs[0] = 20'sh00001; ws[0] = 20'shFFFFF;
        run_op(0, 1, 20'sh00000, 1'b0, "floor", e);
        chk("floor_const", 32'(v_s[0]), 32'(20'hFFFFF));
        chk("floor_lat", 32'(e), 32'd2);
        accept(0, 0, 1'b0, "floor");

        // bubbles, stray out_ready, back-pressure and start in DONE
        for (int k = 0; k < 16; k++) begin
            xs[k] = 20'($urandom);
            ws[k] = 20'($urandom_range(0, 32'h1FFFF)) - 20'sh10000;
        end
        b = 20'($urandom);
        run_op(3, 16, b, 1'b1, "bubble", e);
        accept(3, 10, 1'b1, "bubble");

        // mid-operation reset after 5 of 16 elements
        start_s[3] = 1'b1;
        bias_s[3]  = 20'sh20000;
        tick();
        start_s[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iv_s[3] = 1'b1;
            x_s[3]  = 20'($urandom);
            w_s[3]  = 20'($urandom);
            tick();
        end
        iv_s[3] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_v", 32'(v_s[3]), 32'd0);
        chk("mrst_ov", 32'(ov_s[3]), 32'd0);
        chk("mrst_ir", 32'(irdy_s[3]), 32'd0);
        for (int k = 0; k < 16; k++) begin
            xs[k] = 20'($urandom_range(0, 32'hFFFF)) - 20'sh08000;
            ws[k] = 20'($urandom_range(0, 32'hFFFF)) - 20'sh08000;
        end
        run_op(3, 16, 20'shFF000, 1'b0, "fresh", e);
        chk("fresh_lat", 32'(e), 32'd17);
        accept(3, 2, 1'b0, "fresh");

        // random back-to-back operations on every instance
        for (int r = 0; r < 6; r++) begin
            int d;
            int n;
            d = r % 4;
            n = (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : 16;
            for (int k = 0; k < n; k++) begin
                xs[k] = 20'($urandom);
                ws[k] = 20'($urandom);
            end
            run_op(d, n, 20'($urandom), 1'b1, $sformatf("rand%0d", r), e);
            accept(d, r % 3, 1'b1, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/var_mac.md
# var_mac

Pipelined multiply-accumulate stage that computes the pre-activation value `V_out = bias + Σ x[k]·w[k]` over an N-element stream, in signed Q5.15 (20-bit, 1.0 = 20'sh08000). It sits directly upstream of the softplus stage: its `V_out` drives softplus's `V_out` input. It holds the result stable, with `out_valid` high, until the consumer accepts it.

## Interface

- `N`, default 16: elements per dot product. Legal range is 1..256.
- `clk`  in  1  : single clock; everything is rising-edge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : begins an operation. Sampled only in IDLE.
- `bias`  in  20  : signed Q5.15. Sampled on the edge that accepts `start`.
- `x_in`  in  20  : signed Q5.15 data element.
- `w_in`  in  20  : signed Q5.15 weight element.
- `in_valid`  in  1  : `x_in`/`w_in` pair is valid.
- `in_ready`  out  1  : stage accepts a pair. High only in ACC.
- `V_out`  out  20  : signed Q5.15 result. Registered.
- `out_valid`  out  1  : `V_out` is valid.
- `out_ready`  in  1  : consumer accepts `V_out`.

## Operation

- **States:** IDLE, ACC, DRAIN, DONE.
- **IDLE**
  - `in_ready`=0 and `out_valid`=0.
  - On `start`=1: `acc` ← `bias` sign-extended and shifted left by 15 (Q10.30 alignment), `cnt` ← 0, `prod_v` ← 0, state → ACC.
- **ACC**
  - `in_ready`=1.
  - A handshake is `in_valid` && `in_ready`. On each handshake: `prod_q` ← `x_in`·`w_in` (40-bit signed, Q10.30), `prod_v` ← 1, `cnt` ← `cnt`+1.
  - On a cycle with no handshake, `prod_v` ← 0. Bubbles are allowed at any point.
  - Every edge where `prod_v`=1 does `acc` ← `acc` + `prod_q`.
  - A handshake when `cnt`==N-1 moves state → DRAIN.
- **DRAIN** (one cycle)
  - `in_ready`=0.
  - `V_out` ← sat20((`acc` + (`prod_v` ? `prod_q` : 0)) >>> 15), `out_valid` ← 1, state → DONE.
- **DONE**
  - `V_out` and `out_valid` are held stable.
  - On `out_ready`=1: `out_valid` ← 0, state → IDLE.
  - `start` is ignored in this state.
- **Arithmetic**
  - `acc` is 48-bit signed and cannot overflow for N ≤ 256.
  - `>>> 15` is an arithmetic shift, so the result is floored (rounds toward −∞).
  - sat20 clamps to the range [20'sh80000, 20'sh7FFFF].
  - `V_out` holds its last value in every state except DRAIN, where it is loaded.
- **Boundaries**
  - N=1: the first handshake moves straight to DRAIN.
  - `start` while not IDLE is ignored.
  - `in_valid` outside ACC is ignored.
  - `out_ready` outside DONE is ignored.
  - `rst` at any point aborts the operation and discards partial sums.

## Timing

- **Reset values:** state=IDLE, `V_out`=20'sh00000, `out_valid`=0, `in_ready`=0, `acc`=0, `cnt`=0, `prod_v`=0.
- **Start:** `start` sampled at edge E0 gives `in_ready`=1 from the cycle after E0.
- **Latency:** the last handshake at edge T gives `in_ready`=0 after T. `V_out` and `out_valid`=1 are visible after edge T+1.
- **Total:** with no bubbles, `out_valid` rises N+1 edges after the `start` edge.
- **Pipeline:** the multiplier is registered, with one product in flight. The accumulate happens one edge after the handshake.
- **Turnaround:** `out_ready` at edge R gives IDLE after R. The earliest next `start` is sampled at R+1.
- **Back-pressure:** if `out_ready` is held 0, DONE persists indefinitely with `V_out` unchanged.

## Test plan

1. **Basic dot product:** N=2, `bias`=0, x={20'sh08000, 20'sh10000}, w={20'sh04000, 20'shFC000}, no bubbles. Required: `V_out`=20'shFC000 (−0.5), with `out_valid` rising 3 edges after `start`.
2. **Bias only:** N=4, `bias`=20'sh18000, all x=0 with random w. Required: `V_out`=20'sh18000.
3. **Saturation:** N=1, x=w=20'sh7FFFF gives `V_out`=20'sh7FFFF. Then x=20'sh80000, w=20'sh7FFFF gives `V_out`=20'sh80000.
4. **Floor rounding:** N=1, `bias`=0, x=20'sh00001, w=20'shFFFFF. Required: `V_out`=20'shFFFFF (not 0).
5. **Bubbles and back-pressure:** N=16 with random `in_valid` gaps, and `out_ready` held 0 for 10 cycles. Required: `V_out` matches the reference model, `V_out` is stable while waiting, exactly one accept occurs, and a `start` asserted in DONE is ignored.
6. **Mid-operation reset:** `rst` pulsed after 5 of 16 elements. Required: all outputs return to reset values the next cycle. A fresh operation afterwards gives a correct result with no residue from the aborted sum.
